// File: rtl/ps2_pkg.sv
// ps2_pkg: transmitter state encoding and PS/2 host-to-device frame constants
// shared by ps2_tx and ps2_edge_sync users.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_CLKS = 11;
   localparam bit ODD_PARITY = 1'b1;

   // Last falling edge on which the host still drives the line (the stop bit).
   localparam logic [3:0] LAST_DRIVE_FE = 4'(FRAME_CLKS - 1);

   function automatic logic frame_parity(input logic [DATA_BITS-1:0] data);
      return ODD_PARITY ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 2-FF synchronizers for the PS/2 clock and data lines plus a
// falling-edge strobe on the synchronized clock (seen 1 then 0).
module ps2_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   input  logic dat_in,
   output logic clk_sync,
   output logic dat_sync,
   output logic fe
);

   logic clk_meta;
   logic dat_meta;
   logic clk_prev;

   // Idle PS/2 lines are high, so the synchronizers reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= clk_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= dat_in;
         dat_sync <= dat_meta;
      end
   end

   assign fe = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter (inhibit, request, shift, ACK).
// Define PS2_TX_TIMEOUT_EN to add a frame watchdog of TIMEOUT_CYC cycles.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

   state_t               state;
   state_t               state_nxt;
   logic                 clk_sync;
   logic                 dat_sync;
   logic                 fe;
   logic [DATA_BITS:0]   frame;
   logic [3:0]           shift_cnt;
   logic [INH_W-1:0]     inh_cnt;
   logic                 ack_ok;
   logic                 accept;
   logic                 frame_end;
   logic                 timeout_hit;
   logic                 done_nxt;
   logic                 err_nxt;
   logic                 ready_nxt;
   logic                 busy_nxt;
   logic                 clk_oe_nxt;
   logic                 dat_oe_nxt;

   ps2_edge_sync u_sync (
      .clk      (clk_50),
      .rst      (rst),
      .clk_in   (ps2_clk_in),
      .dat_in   (ps2_dat_in),
      .clk_sync (clk_sync),
      .dat_sync (dat_sync),
      .fe       (fe)
   );

   assign accept    = tx_valid & tx_ready;
   assign frame_end = (state == ST_WAIT_IDLE) & clk_sync & dat_sync;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wdog;

   // Watchdog runs from REQ entry and is held clear while idle or inhibiting.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         wdog <= '0;
      end else if ((state == ST_IDLE) || (state == ST_INHIBIT)) begin
         wdog <= '0;
      end else if (wdog != WD_LAST) begin
         wdog <= wdog + WD_W'(1);
      end else begin
         wdog <= wdog;
      end
   end

   assign timeout_hit = (state != ST_IDLE) && (state != ST_INHIBIT) && (wdog == WD_LAST);
`else
   // No watchdog: the block waits indefinitely for device clocks.
   assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

   // State register.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a watchdog expiry overrides every transition.
   always_comb begin
      state_nxt = state;
      if (timeout_hit) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) state_nxt = ST_INHIBIT;
               else        state_nxt = ST_IDLE;
            end
            ST_INHIBIT: begin
               if (inh_cnt == INH_LAST) state_nxt = ST_REQ;
               else                     state_nxt = ST_INHIBIT;
            end
            ST_REQ: begin
               state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (fe && (shift_cnt == (LAST_DRIVE_FE - 4'd1))) state_nxt = ST_ACK;
               else                                             state_nxt = ST_SHIFT;
            end
            ST_ACK: begin
               if (fe) state_nxt = ST_WAIT_IDLE;
               else    state_nxt = ST_ACK;
            end
            ST_WAIT_IDLE: begin
               if (clk_sync && dat_sync) state_nxt = ST_IDLE;
               else                      state_nxt = ST_WAIT_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Frame latch, saturating counters and ACK capture.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         frame     <= '0;
         shift_cnt <= 4'd0;
         inh_cnt   <= '0;
         ack_ok    <= 1'b0;
      end else begin
         if (accept) begin
            frame  <= {frame_parity(tx_data), tx_data};
            ack_ok <= 1'b0;
         end else if ((state == ST_ACK) && fe) begin
            ack_ok <= ~dat_sync;
         end

         if (state != ST_INHIBIT) begin
            inh_cnt <= '0;
         end else if (inh_cnt != INH_LAST) begin
            inh_cnt <= inh_cnt + INH_W'(1);
         end

         if (state == ST_REQ) begin
            shift_cnt <= 4'd0;
         end else if ((state == ST_SHIFT) && fe && (shift_cnt != LAST_DRIVE_FE)) begin
            shift_cnt <= shift_cnt + 4'd1;
         end
      end
   end

   // Output decode from the upcoming state so every output is registered in
   // step with the state; tx_ready stays low for the pulse cycle.
   always_comb begin
      done_nxt   = frame_end & ack_ok & ~timeout_hit;
      err_nxt    = timeout_hit | (frame_end & ~ack_ok);
      busy_nxt   = (state_nxt != ST_IDLE);
      ready_nxt  = ~busy_nxt & ~done_nxt & ~err_nxt;
      clk_oe_nxt = (state_nxt == ST_INHIBIT);
      case (state_nxt)
         ST_REQ: begin
            dat_oe_nxt = 1'b1;
         end
         ST_SHIFT: begin
            if ((state == ST_SHIFT) && fe) dat_oe_nxt = ~frame[shift_cnt];
            else                           dat_oe_nxt = ps2_dat_oe;
         end
         default: begin
            dat_oe_nxt = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         tx_ready   <= 1'b1;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
         busy       <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         tx_ready   <= ready_nxt;
         tx_done    <= done_nxt;
         tx_err     <= err_nxt;
         busy       <= busy_nxt;
         ps2_clk_oe <= clk_oe_nxt;
         ps2_dat_oe <= dat_oe_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed and randomized frames against an open-drain PS/2 device
// model; expected frame bits come from a byte-level reference function.
`timescale 1ns/1ps
module tb_ps2_tx;

   localparam int INHIBIT = 5000;
   localparam int TIMEOUT = 20000;
   localparam int HALF    = 20;

   logic       clk_50 = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic       busy;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #10 clk_50 = ~clk_50;

   ps2_tx #(.INHIBIT_CYC(INHIBIT), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk_50     (clk_50),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .busy       (busy),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   int checks   = 0;
   int passes   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   always @(posedge clk_50) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: bits a device sees on its rising edges (8 data LSB first, odd parity, stop).
   function automatic logic [9:0] model_bits(input logic [7:0] b);
      logic [9:0] e;
      for (int i = 0; i < 8; i++) e[i] = (((int'(b) >> i) % 2) == 1);
      e[8] = (($countones(b) % 2) == 0);
      e[9] = 1'b1;
      return e;
   endfunction

   task automatic send(input logic [7:0] b);
      int guard = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && guard < 100) begin
         @(negedge clk_50);
         guard++;
      end
      if (!tx_ready) check("send_ready_timeout", 32'(tx_ready), 32'd1);
      @(negedge clk_50);
      tx_valid = 1'b0;
   endtask

   task automatic device_frame(input logic ack, input int abort_at, input logic inject,
                               output logic [9:0] bits, output int inh_len);
      int guard = 0;
      bits    = '0;
      inh_len = 0;
      while (!ps2_clk_oe && guard < 50) begin
         @(negedge clk_50);
         guard++;
      end
      while (ps2_clk_oe && inh_len < INHIBIT + 50) begin
         inh_len++;
         @(negedge clk_50);
      end
      check("start_bit", 32'(ps2_dat_oe), 32'd1);
      for (int i = 0; i < 11; i++) begin
         if (i == 10) dev_dat = ack ? 1'b0 : 1'b1;
         repeat (HALF) @(negedge clk_50);
         dev_clk = 1'b0;
         if (abort_at == i + 1) begin
            repeat (HALF) @(negedge clk_50);
            return;
         end
         if (inject && i == 3) begin
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
            @(negedge clk_50);
            tx_valid = 1'b0;
         end
         repeat (HALF) @(negedge clk_50);
         if (i < 10) bits[i] = ps2_dat_in;
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
   endtask

   task automatic finish_frame(input string tag, input logic exp_ack);
      int guard = 0;
      while (!(tx_done || tx_err) && guard < 200) begin
         @(negedge clk_50);
         guard++;
      end
      check({tag, "_done"}, 32'(tx_done), 32'(exp_ack));
      check({tag, "_err"}, 32'(tx_err), 32'(!exp_ack));
      check({tag, "_ready_in_pulse"}, 32'(tx_ready), 32'd0);
      @(negedge clk_50);
      check({tag, "_ready_back"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] rb;
      logic       ra;
      int         inh;
      int         d0;
      int         e0;

      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk_50);
      rst = 1'b0;
      @(negedge clk_50);
      check("reset_ready", 32'(tx_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_outs", 32'({ps2_clk_oe, ps2_dat_oe, tx_done, tx_err}), 32'd0);

      // 0xED with ACK
      d0 = done_cnt;
      send(8'hED);
      device_frame(1'b1, 0, 1'b0, bits, inh);
      check("ed_inhibit_len", 32'(inh), 32'(INHIBIT));
      check("ed_bits", 32'(bits), 32'(model_bits(8'hED)));
      finish_frame("ed", 1'b1);
      repeat (2) @(negedge clk_50);
      check("ed_done_count", 32'(done_cnt - d0), 32'd1);

      // 0x07 then 0xFF back-to-back
      d0 = done_cnt;
      send(8'h07);
      device_frame(1'b1, 0, 1'b0, bits, inh);
      check("x07_bits", 32'(bits), 32'(model_bits(8'h07)));
      check("x07_parity", 32'(bits[8]), 32'd0);
      finish_frame("x07", 1'b1);
      send(8'hFF);
      device_frame(1'b1, 0, 1'b0, bits, inh);
      check("xff_bits", 32'(bits), 32'(model_bits(8'hFF)));
      check("xff_parity", 32'(bits[8]), 32'd1);
      finish_frame("xff", 1'b1);
      repeat (2) @(negedge clk_50);
      check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

      // Device NACK
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h55);
      device_frame(1'b0, 0, 1'b0, bits, inh);
      finish_frame("nack", 1'b0);
      repeat (2) @(negedge clk_50);
      check("nack_no_done", 32'(done_cnt - d0), 32'd0);
      check("nack_err_count", 32'(err_cnt - e0), 32'd1);
      check("nack_idle", 32'(busy), 32'd0);

      // Reset after the 4th falling edge
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h12);
      device_frame(1'b1, 4, 1'b0, bits, inh);
      rst = 1'b1;
      @(negedge clk_50);
      rst = 1'b0;
      check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      repeat (30) @(negedge clk_50);
      check("rst_no_pulse_later", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      send(8'hF4);
      device_frame(1'b1, 0, 1'b0, bits, inh);
      check("f4_bits", 32'(bits), 32'(model_bits(8'hF4)));
      finish_frame("f4", 1'b1);

      // tx_valid with 0xAA mid-frame is ignored
      send(8'hED);
      device_frame(1'b1, 0, 1'b1, bits, inh);
      check("inject_bits", 32'(bits), 32'(model_bits(8'hED)));
      finish_frame("inject", 1'b1);
      repeat (20) @(negedge clk_50);
      check("inject_no_new_frame", 32'({ps2_clk_oe, busy}), 32'd0);

      // Randomized bytes and responses
      for (int k = 0; k < 2; k++) begin
         rb = 8'($urandom_range(0, 255));
         ra = 1'($urandom_range(0, 1));
         send(rb);
         device_frame(ra, 0, 1'b0, bits, inh);
         check("rand_bits", 32'(bits), 32'(model_bits(rb)));
         finish_frame("rand", ra);
      end

`ifdef PS2_TX_TIMEOUT_EN
      // Device never clocks: watchdog fires TIMEOUT cycles after REQ entry
      begin
         int g = 0;
         int cnt = 0;
         send(8'hED);
         while (ps2_clk_oe && g < INHIBIT + 50) begin
            @(negedge clk_50);
            g++;
         end
         check("to_req_entry", 32'(ps2_dat_oe), 32'd1);
         while (!tx_err && cnt < TIMEOUT + 100) begin
            @(negedge clk_50);
            cnt++;
         end
         check("to_latency", 32'(cnt), 32'(TIMEOUT));
         check("to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
         @(negedge clk_50);
         check("to_ready", 32'(tx_ready), 32'd1);
      end
`endif

      repeat (2) @(negedge clk_50);
      check("never_done_and_err", 32'(both_cnt), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, clock-low inhibit length in clk_50 cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, frame watchdog limit in clk_50 cycles (20 ms).
REQ-003 SHALL have ports:
- clk_50  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  command byte offered.
- tx_data  in  8  command byte, e.g. 0xED (set LEDs).
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse: frame ended with device ACK.
- tx_err  out  1  one-cycle pulse: frame ended without ACK, or timeout.
- busy  out  1  high whenever not IDLE; KBD_Handler discards received bits while high.
- ps2_clk_in  in  1  raw PS/2 clock line.
- ps2_dat_in  in  1  raw PS/2 data line.
- ps2_clk_oe  out  1  1 = pull clock line low; 0 = release.
- ps2_dat_oe  out  1  1 = pull data line low; 0 = release.

Function
REQ-004 SHALL pass ps2_clk_in and ps2_dat_in through 2-FF synchronizers; a device falling edge (fe) SHALL be synchronized clock 1 then 0.
REQ-005 SHALL accept a byte when tx_valid && tx_ready, latch tx_data, and compute odd parity (parity bit = ~^tx_data).
REQ-006 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, with outputs and transitions as below.
- IDLE: both oe = 0.
- INHIBIT: clk_oe = 1 for exactly INHIBIT_CYC cycles; dat_oe = 0.
- REQ: one cycle, dat_oe = 1 (start bit), clk_oe = 0.
- SHIFT: 4-bit counter n = 1..10 of fe; on fe n = 1..8, dat_oe = ~data[n-1] (LSB first); on fe 9, dat_oe = ~parity; on fe 10, dat_oe = 0 (stop bit, line released).
- ACK: on next fe (11th), sample synchronized data; 0 = ACK, 1 = NACK.
- WAIT_IDLE: leave when synchronized clock and data are both 1; then pulse tx_done (ACK) or tx_err (NACK) and enter IDLE.
REQ-007 SHALL ignore tx_valid while busy; no queueing.
REQ-008 tx_done and tx_err SHALL never be asserted in the same cycle.
REQ-009 tx_ready SHALL rise in the cycle after the tx_done or tx_err pulse; back-to-back frames SHALL be allowed.
REQ-010 fe seen in IDLE or INHIBIT SHALL be ignored.
REQ-011 Counters SHALL saturate and never wrap; the inhibit counter SHALL be wide enough for INHIBIT_CYC.

Reset
REQ-012 With rst high at any clk_50 edge, including mid-frame, the next state SHALL be IDLE with both oe = 0, tx_done = 0, tx_err = 0, busy = 0, tx_ready = 1, and all counters cleared.
REQ-013 A frame aborted by reset SHALL produce no tx_done or tx_err pulse.

Configuration
REQ-014 When macro PS2_TX_TIMEOUT_EN is defined, a watchdog SHALL count cycles from REQ entry.
- On reaching TIMEOUT_CYC in any non-IDLE state: both oe = 0, one tx_err pulse, enter IDLE.
- The watchdog SHALL clear on entry to IDLE.
REQ-015 When PS2_TX_TIMEOUT_EN is undefined, the watchdog SHALL be absent and the block SHALL wait indefinitely for device clocks.

Structure
REQ-016 Package ps2_pkg SHALL hold the state enumeration and PS/2 frame constants: 8 data bits, 11 clocks per frame, odd parity.
REQ-017 Synchronizer plus falling-edge detector SHALL be sub-module ps2_edge_sync, reusable by KBD_Handler.

Verification
REQ-018 Bench SHALL cover these scenarios:
- Send 0xED, device model ACKs: clk_oe high exactly 5000 cycles; data bits seen at device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1; exactly one tx_done; tx_ready back to 1.
- Send 0x07: parity bit 0. Then send 0xFF immediately after tx_done: parity bit 1; two tx_done pulses total.
- Device holds data high on 11th clock: one tx_err, no tx_done; IDLE reached after lines idle.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYC = 20000, device model never clocks: tx_err exactly 20000 cycles after REQ entry; both oe = 0.
- rst asserted after 4th fe: next cycle both oe = 0, busy = 0, no done/err pulse; a new 0xF4 frame then completes with ACK.
- tx_valid pulsed with 0xAA during a 0xED frame: ignored; only 0xED bits appear on the line.
